// File: rtl/pll_drp_divider_bank.sv
// CMT output-divider bank: DRP register file, lock sequencer and NUM_OUT
// HIGH/LOW/DELAY waveform counters, all on CLKIN.
module pll_drp_divider_bank #(
    parameter int unsigned NUM_OUT     = 6,
    parameter int unsigned CNT_W       = 6,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic               CLKIN,
    input  logic               RST,
    input  logic               PWRDWN,
    input  logic               DEN,
    input  logic               DWE,
    input  logic [6:0]         DADDR,
    input  logic [15:0]        DI,
    output logic [15:0]        DO,
    output logic               DRDY,
    output logic               LOCKED,
    output logic [NUM_OUT-1:0] CLKOUT
);

    localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {DrpIdle, DrpBusy, DrpAck} drp_state_t;
    typedef enum logic [1:0] {LkReset, LkCount, LkLocked} lock_state_t;
    typedef enum logic [1:0] {ChIdle, ChDelay, ChHigh, ChLow} ch_state_t;

    drp_state_t  drp_q, drp_d;
    lock_state_t lock_q, lock_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;

    logic [6:0]  addr_q;
    logic        we_q;
    logic [15:0] wdata_q;

    logic [NUM_OUT-1:0] oe_q, nocount_q;
    logic [CNT_W-1:0]   high_q  [NUM_OUT];
    logic [CNT_W-1:0]   low_q   [NUM_OUT];
    logic [CNT_W-1:0]   delay_q [NUM_OUT];

    ch_state_t          ch_q [NUM_OUT];
    ch_state_t          ch_d [NUM_OUT];
    logic [CNT_W-1:0]   cc_q [NUM_OUT];
    logic [CNT_W-1:0]   cc_d [NUM_OUT];
    logic [NUM_OUT-1:0] clkout_q, clkout_d;

    logic        mapped, is_reg2, commit, run;
    logic [2:0]  sel_ch;
    logic [15:0] rdata;
    logic        unused_wdata;

    assign unused_wdata = ^wdata_q[15:2*CNT_W+1];

    // Decode of the address latched when the access was accepted.
    always_comb begin
        mapped  = (addr_q >= 7'd8) && (addr_q < 7'(8 + 2 * NUM_OUT));
        is_reg2 = addr_q[0];
        sel_ch  = 3'((addr_q - 7'd8) >> 1);
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (mapped && sel_ch == 3'(k)) begin
                if (is_reg2) rdata = 16'({nocount_q[k], delay_q[k]});
                else         rdata = 16'({oe_q[k], high_q[k], low_q[k]});
            end
        end
    end

    always_comb begin
        drp_d = drp_q;
        unique case (drp_q)
            DrpIdle: if (DEN) drp_d = DrpBusy;
            DrpBusy: drp_d = DrpAck;
            DrpAck:  drp_d = DrpIdle;
            default: drp_d = DrpIdle;
        endcase
    end

    assign commit = (drp_q == DrpAck) && we_q && mapped;
    assign DRDY   = (drp_q == DrpAck);
    assign DO     = (drp_q == DrpAck && !we_q) ? rdata : '0;

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            drp_q   <= DrpIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            drp_q <= drp_d;
            if (drp_q == DrpIdle && DEN) begin
                addr_q  <= DADDR;
                we_q    <= DWE;
                wdata_q <= DI;
            end
        end
    end

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            oe_q      <= '0;
            nocount_q <= '1;
            for (int k = 0; k < NUM_OUT; k++) begin
                high_q[k]  <= CNT_W'(1);
                low_q[k]   <= CNT_W'(1);
                delay_q[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (sel_ch == 3'(k)) begin
                    if (is_reg2) begin
                        nocount_q[k] <= wdata_q[CNT_W];
                        delay_q[k]   <= wdata_q[CNT_W-1:0];
                    end else begin
                        oe_q[k]   <= wdata_q[2*CNT_W];
                        high_q[k] <= wdata_q[2*CNT_W-1:CNT_W];
                        low_q[k]  <= wdata_q[CNT_W-1:0];
                    end
                end
            end
        end
    end

    // A committed write restarts lock even on the terminal-count cycle.
    always_comb begin
        lock_d = lock_q;
        lcnt_d = lcnt_q;
        if (PWRDWN) begin
            lock_d = LkReset;
            lcnt_d = '0;
        end else if (commit) begin
            lock_d = LkCount;
            lcnt_d = '0;
        end else begin
            unique case (lock_q)
                LkReset: begin
                    lock_d = LkCount;
                    lcnt_d = '0;
                end
                LkCount: begin
                    if (lcnt_q == LCW'(LOCK_CYCLES)) lock_d = LkLocked;
                    else                             lcnt_d = lcnt_q + LCW'(1);
                end
                LkLocked: lock_d = LkLocked;
                default:  lock_d = LkReset;
            endcase
        end
    end

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            lock_q <= LkCount;
            lcnt_q <= '0;
        end else begin
            lock_q <= lock_d;
            lcnt_q <= lcnt_d;
        end
    end

    assign LOCKED = (lock_q == LkLocked);

    // Channels follow the next lock state so they start on the edge LOCKED rises.
    assign run = (lock_d == LkLocked);

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            ch_d[k]     = ch_q[k];
            cc_d[k]     = cc_q[k] + CNT_W'(1);
            clkout_d[k] = 1'b0;
            if (!run) begin
                ch_d[k] = ChIdle;
                cc_d[k] = '0;
            end else begin
                unique case (ch_q[k])
                    ChIdle: begin
                        cc_d[k] = '0;
                        ch_d[k] = (delay_q[k] != '0) ? ChDelay : ChHigh;
                    end
                    ChDelay: begin
                        if (cc_q[k] == delay_q[k] - CNT_W'(1)) begin
                            ch_d[k] = ChHigh;
                            cc_d[k] = '0;
                        end
                    end
                    ChHigh: begin
                        if (cc_q[k] == high_q[k] - CNT_W'(1)) begin
                            ch_d[k] = ChLow;
                            cc_d[k] = '0;
                        end
                    end
                    ChLow: begin
                        if (cc_q[k] == low_q[k] - CNT_W'(1)) begin
                            ch_d[k] = ChHigh;
                            cc_d[k] = '0;
                        end
                    end
                    default: begin
                        ch_d[k] = ChIdle;
                        cc_d[k] = '0;
                    end
                endcase
            end
            if (ch_d[k] != ChIdle && oe_q[k]) begin
                clkout_d[k] = nocount_q[k] | (ch_d[k] == ChHigh);
            end
        end
    end

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                ch_q[k] <= ChIdle;
                cc_q[k] <= '0;
            end
            clkout_q <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                ch_q[k] <= ch_d[k];
                cc_q[k] <= cc_d[k];
            end
            clkout_q <= clkout_d;
        end
    end

    assign CLKOUT = clkout_q;

endmodule
